fc1_accum_sequencer: RTL and testbench

Sequencer for the stage-3 FC1 layer. Accepts the pooled activation stream one value per beat, drives the weight-ROM address, and accumulates CO signed partial sums in parallel over a frame of N_IN inputs. After each frame it emits a one-cycle valid pulse with the packed accumulator vector, which feeds the FC1 bias-add core's valid/accumulator inputs directly. It owns frame counting, accumulator clearing and input flow control for the FC1 datapath.

---
 rtl/fc1_accum_sequencer.sv | 113 +++++++++++
 tb/tb_fc1_accum_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fc1_accum_sequencer.sv
// fc1_accum_sequencer: frame sequencer and parallel MAC for the stage-3 FC1 layer.
// Latency: result on o_acc with a one-cycle o_acc_valid pulse, one cycle after the last beat is accepted.
// Backpressure: o_in_ready drops only in the single EMIT cycle; otherwise every offered beat is taken.
//
// Ports:
//   clk, reset         single rising-edge clock, asynchronous active-high reset
//   i_in_valid/i_in_data/o_in_ready   activation stream (unsigned), valid/ready handshake
//   i_soft_clear       synchronous abort of a partial frame (ignored while emitting)
//   o_w_addr/i_w_data  weight-ROM address (index of the next beat) and same-cycle weights
//   o_acc_valid/o_acc  frame result pulse and holding register, channel c at [c*ACC_BW +: ACC_BW]
//   o_busy             high while a frame is in progress or being emitted
`timescale 1ns/1ps
module fc1_accum_sequencer #(
    parameter int N_IN   = 48,
    parameter int CO     = 3,
    parameter int IN_BW  = 8,
    parameter int W_BW   = 8,
    parameter int ACC_BW = 22,
    parameter int AW     = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_in_valid,
    input  logic [IN_BW-1:0]       i_in_data,
    output logic                   o_in_ready,
    input  logic                   i_soft_clear,
    output logic [AW-1:0]          o_w_addr,
    input  logic [CO*W_BW-1:0]     i_w_data,
    output logic                   o_acc_valid,
    output logic [CO*ACC_BW-1:0]   o_acc,
    output logic                   o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(N_IN - 1);
    localparam int            PROD_BW  = IN_BW + W_BW + 1;

    state_t                 state;
    logic [AW-1:0]          count;
    logic [CO*ACC_BW-1:0]   acc;
    logic [CO*ACC_BW-1:0]   acc_sum;
    logic signed [PROD_BW-1:0] prod [CO];

    logic beat;
    logic last_beat;

    // o_in_ready is only high in IDLE/ACCUM, so a beat can never land in EMIT.
    // A coincident soft clear discards the beat.
    assign beat      = i_in_valid & o_in_ready & ~i_soft_clear;
    assign last_beat = beat & (count == LAST_IDX);

    assign o_w_addr = count;
    assign o_busy   = (state != IDLE);

    // Activation is zero-extended before the signed multiply so 255 stays +255.
    always_comb begin
        acc_sum = '0;
        for (int c = 0; c < CO; c++) begin
            prod[c] = $signed({1'b0, i_in_data}) * $signed(i_w_data[c*W_BW +: W_BW]);
            acc_sum[c*ACC_BW +: ACC_BW] = $signed(acc[c*ACC_BW +: ACC_BW]) + ACC_BW'(prod[c]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            acc         <= '0;
            o_acc       <= '0;
            o_acc_valid <= 1'b0;
            o_in_ready  <= 1'b0;
        end else begin
            o_acc_valid <= 1'b0;
            o_in_ready  <= 1'b1;
            case (state)
                IDLE, ACCUM: begin
                    if (i_soft_clear) begin
                        acc   <= '0;
                        count <= '0;
                        state <= IDLE;
                    end else if (last_beat) begin
                        // Final sums go straight to the holding register; the
                        // running accumulators are cleared for the next frame.
                        o_acc       <= acc_sum;
                        acc         <= '0;
                        count       <= '0;
                        state       <= EMIT;
                        o_acc_valid <= 1'b1;
                        o_in_ready  <= 1'b0;
                    end else if (beat) begin
                        acc   <= acc_sum;
                        count <= count + AW'(1);
                        state <= ACCUM;
                    end
                end
                EMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    acc   <= '0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc1_accum_sequencer.sv
`timescale 1ns/1ps
module tb_fc1_accum_sequencer;

    logic                clk = 1'b0;
    logic                reset;
    logic                i_in_valid;
    logic [7:0]          i_in_data;
    logic                o_in_ready;
    logic                i_soft_clear;
    logic [5:0]          o_w_addr;
    logic [23:0]         i_w_data;
    logic                o_acc_valid;
    logic [65:0]         o_acc;
    logic                o_busy;

    logic signed [7:0]   w0, w1, w2;
    assign i_w_data = {w2, w1, w0};

    fc1_accum_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .i_in_valid   (i_in_valid),
        .i_in_data    (i_in_data),
        .o_in_ready   (o_in_ready),
        .i_soft_clear (i_soft_clear),
        .o_w_addr     (o_w_addr),
        .i_w_data     (i_w_data),
        .o_acc_valid  (o_acc_valid),
        .o_acc        (o_acc),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    logic prev_valid = 1'b0;
    logic [65:0] exp_q [$];

    function automatic logic [65:0] pk(input int a, input int b, input int c);
        return {22'(c), 22'(b), 22'(a)};
    endfunction

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every result pulse pops one expected vector.
    always @(negedge clk) begin
        if (!reset) begin
            if (o_acc_valid) begin
                pulses++;
                check("emit_not_ready", {65'd0, o_in_ready}, 66'd0);
                check("valid_not_consecutive", {65'd0, prev_valid}, 66'd0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: got o_acc %0h, required no pulse", o_acc);
                end else begin
                    check("acc_result", o_acc, exp_q.pop_front());
                end
            end
            prev_valid = o_acc_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic beat(input logic [7:0] d, input int idx);
        int tries;
        tries = 0;
        i_in_valid = 1'b1;
        i_in_data  = d;
        while (!o_in_ready && tries < 10) begin
            @(posedge clk); #1;
            tries++;
        end
        if (!o_in_ready) begin
            tests++;
            fails++;
            $display("FAIL beat_timeout: got ready 0 for beat %0d, required 1", idx);
        end
        check("w_addr", {60'd0, o_w_addr}, 66'(idx));
        @(posedge clk); #1;
        i_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int acc_cnt;
        int cyc;
        logic took;

        reset = 1'b1; i_in_valid = 1'b0; i_in_data = '0; i_soft_clear = 1'b0;
        w0 = 0; w1 = 0; w2 = 0;
        #3;
        check("rst_ready", {65'd0, o_in_ready}, 66'd0);
        check("rst_valid", {65'd0, o_acc_valid}, 66'd0);
        check("rst_acc", o_acc, 66'd0);
        check("rst_addr", {60'd0, o_w_addr}, 66'd0);
        check("rst_busy", {65'd0, o_busy}, 66'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", {65'd0, o_in_ready}, 66'd1);

        // Basic frame
        w0 = 1; w1 = -1; w2 = 2;
        exp_q.push_back(pk(48, -48, 96));
        for (int i = 0; i < 48; i++) beat(8'd1, i);
        check("busy_in_emit", {65'd0, o_busy}, 66'd1);
        @(negedge clk);
        check("latency_valid", {65'd0, o_acc_valid}, 66'd1);
        @(posedge clk); #1;
        check("valid_drop", {65'd0, o_acc_valid}, 66'd0);
        check("addr_wrap", {60'd0, o_w_addr}, 66'd0);
        check("busy_after", {65'd0, o_busy}, 66'd0);
        check("ready_after_emit", {65'd0, o_in_ready}, 66'd1);

        // Extreme magnitude
        w0 = -128; w1 = 127; w2 = 0;
        exp_q.push_back(pk(-1566720, 1554480, 0));
        for (int i = 0; i < 48; i++) beat(8'd255, i);
        idle(3);

        // Gappy input
        w0 = 1; w1 = 0; w2 = 0;
        exp_q.push_back(pk(1128, 0, 0));
        p0 = pulses;
        for (int i = 0; i < 48; i++) begin
            idle($urandom_range(0, 5));
            beat(8'(i), i);
            check("gappy_busy", {65'd0, o_busy}, 66'd1);
        end
        idle(3);
        check("gappy_one_pulse", 66'(pulses - p0), 66'd1);

        // Soft clear coincident with beat 20
        w0 = 1; w1 = 1; w2 = 1;
        for (int i = 0; i < 20; i++) beat(8'd5, i);
        i_in_valid = 1'b1; i_in_data = 8'd9; i_soft_clear = 1'b1;
        @(posedge clk); #1;
        i_in_valid = 1'b0; i_soft_clear = 1'b0;
        check("clear_addr", {60'd0, o_w_addr}, 66'd0);
        check("clear_busy", {65'd0, o_busy}, 66'd0);
        exp_q.push_back(pk(96, 96, 96));
        for (int i = 0; i < 48; i++) beat(8'd2, i);
        idle(3);

        // Asynchronous reset mid-frame: no pulse, everything back to reset values
        for (int i = 0; i < 10; i++) beat(8'd7, i);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check("midrst_addr", {60'd0, o_w_addr}, 66'd0);
        check("midrst_busy", {65'd0, o_busy}, 66'd0);
        check("midrst_ready", {65'd0, o_in_ready}, 66'd0);
        check("midrst_acc", o_acc, 66'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready_after", {65'd0, o_in_ready}, 66'd1);

        // Continuous valid over two frames
        w0 = 1; w1 = 2; w2 = -1;
        exp_q.push_back(pk(48, 96, -48));
        exp_q.push_back(pk(96, 192, -96));
        i_in_valid = 1'b1; i_in_data = 8'd1;
        acc_cnt = 0; cyc = 0;
        while (acc_cnt < 96 && cyc < 300) begin
            took = o_in_ready & i_in_valid;
            @(posedge clk); #1;
            cyc++;
            if (took) begin
                acc_cnt++;
                if (acc_cnt == 48) begin
                    i_in_data = 8'd2;
                    check("bp_emit1_ready", {65'd0, o_in_ready}, 66'd0);
                end
                if (acc_cnt == 60) check("bp_hold_f1", o_acc, pk(48, 96, -48));
                if (acc_cnt == 96) begin
                    i_in_valid = 1'b0;
                    check("bp_emit2_ready", {65'd0, o_in_ready}, 66'd0);
                end
            end
        end
        if (acc_cnt != 96) begin
            tests++;
            fails++;
            $display("FAIL bp_timeout: got %0d beats, required 96", acc_cnt);
        end
        idle(3);

        check("queue_drained", 66'(exp_q.size()), 66'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
